// File: rtl/motor_rotation_scheduler_if.sv
// motor_rotation_scheduler_if: panel-side inputs and driver-side outputs of the motor rotation scheduler
interface motor_rotation_scheduler_if #(
    parameter int N_MOTORS = 4
);
    localparam int ID_W = N_MOTORS > 1 ? $clog2(N_MOTORS) : 1;
    logic                  enable;
    logic                  test_mode;
    logic [N_MOTORS-1:0]   req;
    logic [N_MOTORS-1:0]   fault;
    logic                  fault_clr;
    logic [N_MOTORS-1:0]   motor_on;
    logic [ID_W-1:0]       cur_id;
    logic                  busy;
    logic                  dead;
    logic [N_MOTORS-1:0]   fault_lat;
    logic [16*N_MOTORS-1:0] slot_cnt;
    modport master (
        output enable, test_mode, req, fault, fault_clr,
        input  motor_on, cur_id, busy, dead, fault_lat, slot_cnt
    );
    modport slave (
        input  enable, test_mode, req, fault, fault_clr,
        output motor_on, cur_id, busy, dead, fault_lat, slot_cnt
    );
endinterface

// File: rtl/motor_rotation_scheduler.sv
// motor_rotation_scheduler: round-robin single-motor power sharing with dead time and fault latching
// Optional per-motor completed-slot counters: define MOTOR_SCHED_SLOT_CNT_EN.
module motor_rotation_scheduler #(
    parameter int N_MOTORS      = 4,
    parameter int CLK_FREQ_HZ   = 25_000_000,
    parameter int SLOT_CYC      = 30 * CLK_FREQ_HZ,
    parameter int TEST_SLOT_CYC = 3 * CLK_FREQ_HZ,
    parameter int DEAD_CYC      = CLK_FREQ_HZ / 10
) (
    input logic clk,
    input logic rst,
    motor_rotation_scheduler_if.slave bus
);
    localparam int ID_W  = N_MOTORS > 1 ? $clog2(N_MOTORS) : 1;
    localparam int MAX_S = SLOT_CYC > TEST_SLOT_CYC ? SLOT_CYC : TEST_SLOT_CYC;
    localparam int SW    = $clog2(MAX_S + 1);
    localparam int DW    = $clog2(DEAD_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t              state, state_n;
    logic [N_MOTORS-1:0] elig, sel, on_n;
    logic [ID_W-1:0]     last_id, last_n, id_n, gnt_id;
    logic [SW-1:0]       scnt, scnt_n, slot_len;
    logic [DW-1:0]       dcnt, dcnt_n;
    logic                tsel, tsel_n, gnt_ok, stop, expire, others;

    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] b, input int k);
        return ID_W'((int'(b) + k) % N_MOTORS);
    endfunction

    assign elig     = bus.req & ~bus.fault_lat & ~bus.fault;
    assign sel      = N_MOTORS'(1) << bus.cur_id;
    assign stop     = ~bus.enable | ~elig[bus.cur_id];
    assign expire   = scnt == SW'(1);
    assign others   = |(elig & ~sel);
    assign slot_len = tsel ? SW'(TEST_SLOT_CYC) : SW'(SLOT_CYC);

    // Descending scan so the nearest index after last_id wins.
    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        for (int k = N_MOTORS; k >= 1; k--) begin
            if (elig[nxt(last_id, k)]) begin
                gnt_ok = 1'b1;
                gnt_id = nxt(last_id, k);
            end
        end
    end

    always_comb begin
        state_n = state;
        on_n    = '0;
        id_n    = bus.cur_id;
        last_n  = last_id;
        scnt_n  = scnt;
        dcnt_n  = DW'(DEAD_CYC);
        tsel_n  = tsel;
        case (state)
            IDLE: if (bus.enable && gnt_ok) begin
                state_n = RUN;
                on_n    = N_MOTORS'(1) << gnt_id;
                id_n    = gnt_id;
                last_n  = gnt_id;
                tsel_n  = bus.test_mode;
                scnt_n  = bus.test_mode ? SW'(TEST_SLOT_CYC) : SW'(SLOT_CYC);
            end
            RUN: begin
                if (stop) state_n = DEAD;
                else if (expire) begin
                    state_n = others ? DEAD : RUN;
                    on_n    = others ? '0 : sel;
                    scnt_n  = slot_len;
                end else begin
                    on_n   = sel;
                    scnt_n = scnt - SW'(1);
                end
            end
            DEAD: begin
                dcnt_n  = dcnt - DW'(1);
                state_n = dcnt == DW'(1) ? IDLE : DEAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.motor_on <= '0;
            bus.cur_id   <= '0;
            last_id      <= ID_W'(N_MOTORS - 1);
            bus.busy     <= 1'b0;
            bus.dead     <= 1'b0;
            scnt         <= '0;
            dcnt         <= '0;
            tsel         <= 1'b0;
        end else begin
            state        <= state_n;
            bus.motor_on <= on_n;
            bus.cur_id   <= id_n;
            last_id      <= last_n;
            bus.busy     <= state_n == RUN;
            bus.dead     <= state_n == DEAD;
            scnt         <= scnt_n;
            dcnt         <= dcnt_n;
            tsel         <= tsel_n;
        end
    end

    // A live fault always re-sets its latch, so it beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) bus.fault_lat <= '0;
        else bus.fault_lat <= bus.fault | (bus.fault_lat & ~{N_MOTORS{bus.fault_clr}});
    end

`ifdef MOTOR_SCHED_SLOT_CNT_EN
    logic done;
    assign done = state == RUN && !stop && expire;
    for (genvar i = 0; i < N_MOTORS; i++) begin : g_cnt
        logic [15:0] c;
        always_ff @(posedge clk) begin
            if (rst) c <= '0;
            else if (done && bus.cur_id == ID_W'(i) && c != 16'hFFFF) c <= c + 16'd1;
        end
        assign bus.slot_cnt[16*i +: 16] = c;
    end
`else
    assign bus.slot_cnt = '0;
`endif
endmodule

// File: tb/tb_motor_rotation_scheduler.sv
// tb_motor_rotation_scheduler: directed checks of rotation, sole requester, faults, enable drop and reset
module tb_motor_rotation_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] cnt [3];

    motor_rotation_scheduler_if #(.N_MOTORS(3)) bus ();

    motor_rotation_scheduler #(
        .N_MOTORS(3), .CLK_FREQ_HZ(100), .SLOT_CYC(20), .TEST_SLOT_CYC(5), .DEAD_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] exp_sc();
`ifdef MOTOR_SCHED_SLOT_CNT_EN
        return {cnt[2], cnt[1], cnt[0]};
`else
        return 48'd0;
`endif
    endfunction

    always @(negedge clk) if (!rst) chk("onehot", 64'($countones(bus.motor_on) <= 1), 64'd1);

    initial begin
        for (int i = 0; i < 3; i++) cnt[i] = '0;
        bus.enable = 1'b0;
        bus.test_mode = 1'b0;
        bus.req = 3'b000;
        bus.fault = 3'b000;
        bus.fault_clr = 1'b0;
        tick(2);
        chk("rst_on", 64'(bus.motor_on), 64'd0);
        chk("rst_id", 64'(bus.cur_id), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_dead", 64'(bus.dead), 64'd0);
        chk("rst_flat", 64'(bus.fault_lat), 64'd0);
        chk("rst_sc", 64'(bus.slot_cnt), 64'd0);

        // rotation 0 -> 1 -> 2 -> 0
        rst = 1'b0;
        bus.enable = 1'b1;
        bus.req = 3'b111;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("rot_on", 64'(bus.motor_on), 64'(3'b001 << (i % 3)));
            chk("rot_id", 64'(bus.cur_id), 64'(i % 3));
            chk("rot_busy", 64'(bus.busy), 64'd1);
            tick(19);
            chk("rot_hold", 64'(bus.motor_on), 64'(3'b001 << (i % 3)));
            tick(1);
            cnt[i % 3]++;
            chk("rot_off", 64'(bus.motor_on), 64'd0);
            chk("rot_dead", 64'(bus.dead), 64'd1);
            chk("rot_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
            tick(4);
            chk("rot_idle", 64'({bus.dead, bus.busy, bus.motor_on}), 64'd0);
            tick(1);
        end

        // enable drop while motor 1 runs
        chk("en_on", 64'(bus.motor_on), 64'b010);
        tick(3);
        bus.enable = 1'b0;
        tick(1);
        chk("en_off", 64'(bus.motor_on), 64'd0);
        chk("en_dead", 64'(bus.dead), 64'd1);
        tick(4);
        chk("en_idle_dead", 64'(bus.dead), 64'd0);
        tick(3);
        chk("en_nogrant", 64'({bus.busy, bus.motor_on}), 64'd0);
        chk("en_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
        bus.enable = 1'b1;
        tick(1);
        chk("reen_on", 64'(bus.motor_on), 64'b100);
        chk("reen_id", 64'(bus.cur_id), 64'd2);
        tick(19);
        tick(1);
        cnt[2]++;
        chk("m2_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
        tick(5);
        chk("m0_on", 64'(bus.motor_on), 64'b001);

        // fault on motor 0 mid-slot
        tick(5);
        bus.fault = 3'b001;
        tick(1);
        chk("flt_off", 64'(bus.motor_on), 64'd0);
        chk("flt_lat", 64'(bus.fault_lat), 64'b001);
        chk("flt_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
        tick(4);
        chk("flt_gap", 64'(bus.motor_on), 64'd0);
        tick(1);
        chk("flt_next", 64'(bus.motor_on), 64'b010);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("clr_blocked", 64'(bus.fault_lat), 64'b001);
        bus.fault = 3'b000;
        tick(1);
        chk("flt_held", 64'(bus.fault_lat), 64'b001);
        bus.fault_clr = 1'b1;
        tick(1);
        bus.fault_clr = 1'b0;
        chk("clr_ok", 64'(bus.fault_lat), 64'd0);
        chk("clr_run", 64'(bus.motor_on), 64'b010);

        // sole requester in test mode
        bus.enable = 1'b0;
        tick(5);
        bus.req = 3'b010;
        bus.test_mode = 1'b1;
        bus.enable = 1'b1;
        tick(1);
        chk("solo_on", 64'(bus.motor_on), 64'b010);
        for (int c = 1; c <= 15; c++) begin
            tick(1);
            chk("solo_hold", 64'(bus.motor_on), 64'b010);
            chk("solo_dead", 64'(bus.dead), 64'd0);
            if (c % 5 == 0) begin
                cnt[1]++;
                chk("solo_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
            end
            bus.fault = c == 7 ? 3'b100 : 3'b000;
        end
        chk("solo_flat", 64'(bus.fault_lat), 64'b100);

        // reset mid-run
        rst = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) cnt[i] = '0;
        chk("mrst_on", 64'(bus.motor_on), 64'd0);
        chk("mrst_id", 64'(bus.cur_id), 64'd0);
        chk("mrst_flat", 64'(bus.fault_lat), 64'd0);
        chk("mrst_sc", 64'(bus.slot_cnt), 64'(exp_sc()));
        chk("mrst_busy", 64'({bus.busy, bus.dead}), 64'd0);
        rst = 1'b0;
        bus.req = 3'b111;
        bus.test_mode = 1'b0;
        tick(1);
        chk("post_on", 64'(bus.motor_on), 64'b001);
        chk("post_id", 64'(bus.cur_id), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
